// File: rtl/pipeline_mem_ctrl_pkg.sv
// rtl/pipeline_mem_ctrl_pkg.sv - shared encodings and control-word type for the pipeline memory controller
package pipeline_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DATA = 2'd1
    } state_t;

    localparam logic MEM_SEL_IF  = 1'b0;
    localparam logic MEM_SEL_MEM = 1'b1;

    typedef struct packed {
        logic mem_sel;
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = '{
        mem_sel: MEM_SEL_IF, pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
        idex_en: 1'b1, idex_flush: 1'b0, exmem_en: 1'b1, memwb_bubble: 1'b0
    };

    localparam ctrl_t CTRL_RESET = '{
        mem_sel: MEM_SEL_IF, pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
        idex_en: 1'b0, idex_flush: 1'b1, exmem_en: 1'b0, memwb_bubble: 1'b1
    };

    // Whole pipeline holds while the data access is outstanding.
    localparam ctrl_t CTRL_FREEZE = '{
        mem_sel: MEM_SEL_MEM, pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
        idex_en: 1'b0, idex_flush: 1'b0, exmem_en: 1'b0, memwb_bubble: 1'b1
    };

endpackage

// File: rtl/pipeline_mem_ctrl_luh.sv
// rtl/pipeline_mem_ctrl_luh.sv - combinational load-use hazard detection between ID and EX
module load_use_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    output logic       luh
);

    assign luh = ex_memread && (ex_rd != 5'd0) && ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));

endmodule

// File: rtl/pipeline_mem_ctrl.sv
// rtl/pipeline_mem_ctrl.sv - stall/flush sequencer sharing one memory port between fetch and data access
module pipeline_mem_ctrl
    import pipeline_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             mem_sel,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t          state_q;
    state_t          state_d;
    ctrl_t           ctrl;
    logic            luh;
    logic [TO_W-1:0] to_cnt;

    load_use_detect u_luh (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_rd      (ex_rd),
        .ex_memread (ex_memread),
        .luh        (luh)
    );

    always_comb begin
        ctrl    = CTRL_RUN;
        state_d = state_q;
        if (rst) begin
            ctrl    = CTRL_RESET;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_DATA: begin
                    if (!mem_ready) begin
                        ctrl = CTRL_FREEZE;
                    end else begin
                        ctrl.mem_sel    = MEM_SEL_MEM;
                        ctrl.pc_en      = 1'b0;
                        ctrl.ifid_flush = 1'b1;
                        state_d         = ST_RUN;
                    end
                end
                default: begin
                    if (mem_access) begin
                        if (!mem_ready) begin
                            ctrl    = CTRL_FREEZE;
                            state_d = ST_DATA;
                        end else begin
                            // Data access wins the port; the fetch slot is lost unless a branch redirects.
                            ctrl.mem_sel    = MEM_SEL_MEM;
                            ctrl.pc_en      = ex_branch_taken;
                            ctrl.ifid_flush = 1'b1;
                            ctrl.idex_flush = ex_branch_taken;
                        end
                    end else if (ex_branch_taken) begin
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                    end else if (luh) begin
                        ctrl.pc_en      = 1'b0;
                        ctrl.ifid_en    = 1'b0;
                        ctrl.idex_flush = 1'b1;
                    end else if (!mem_ready) begin
                        ctrl.pc_en      = 1'b0;
                        ctrl.ifid_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            to_cnt    <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (mem_ready) begin
                to_cnt <= '0;
            end else begin
                if (to_cnt != TO_W'(TIMEOUT)) begin
                    to_cnt <= to_cnt + 1'b1;
                end
                if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    err <= 1'b1;
                end
            end
            if (!ctrl.pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign mem_sel      = ctrl.mem_sel;
    assign pc_en        = ctrl.pc_en;
    assign ifid_en      = ctrl.ifid_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_en      = ctrl.idex_en;
    assign idex_flush   = ctrl.idex_flush;
    assign exmem_en     = ctrl.exmem_en;
    assign memwb_bubble = ctrl.memwb_bubble;
    assign state        = state_q;

endmodule
